// File: rtl/servo_pkg.sv
// Shared constants for the servo command path: derived timing values,
// servo_pwm frame constants and the slew controller state encoding.
package servo_pkg;

  localparam int PWM_PERIOD_US = 20000;
  localparam int PWM_MIN_US    = 1000;
  localparam int PWM_MAX_US    = 2000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_MOVE = 2'd2
  } slew_state_t;

  function automatic int center_us(input int min_us, input int max_us);
    return (min_us + max_us) / 2;
  endfunction

  function automatic int frame_ticks(input int clk_freq, input int frame_hz);
    return clk_freq / frame_hz;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. start is honoured
// only while idle; done pulses for one cycle when quot is valid.
module seq_divider #(
  parameter int W = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  numer,
  input  logic [W-1:0]  denom,
  output logic          done,
  output logic [15:0]   quot
);

  localparam int CNT_W = $clog2(W + 1);

  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     rem_r;
  logic [W-1:0]     quo_r;
  logic [W-1:0]     den_r;

  logic [W:0]       rem_sh_s;
  logic [W:0]       trial_s;
  logic [W-1:0]     rem_nx_s;
  logic [W-1:0]     quo_nx_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[W-1]};
    trial_s  = rem_sh_s - {1'b0, den_r};
    if (trial_s[W] == 1'b0) begin
      rem_nx_s = trial_s[W-1:0];
      quo_nx_s = {quo_r[W-2:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[W-1:0];
      quo_nx_s = {quo_r[W-2:0], 1'b0};
    end
  end

  // Divider sequencing: load on start, iterate W times, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      den_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (!busy_r && start) begin
        busy_r <= 1'b1;
        cnt_r  <= CNT_W'(W);
        rem_r  <= '0;
        quo_r  <= numer;
        den_r  <= denom;
      end else if (busy_r) begin
        rem_r <= rem_nx_s;
        quo_r <= quo_nx_s;
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign done = done_r;
  assign quot = quo_r[15:0];

endmodule

// File: rtl/servo_slew_ctrl.sv
// Angle command to pulse-width converter with per-frame slew limiting;
// pulse_us feeds servo_pwm directly.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int FRAME_HZ = 50,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int MAX_DEG  = 180,
  parameter int STEP_US  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_deg,
  output logic [15:0] pulse_us,
  output logic        at_target,
  output logic        frame_tick
);

  localparam int FRAME_TICKS = frame_ticks(CLK_FREQ, FRAME_HZ);
  localparam int CNT_W       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int CENTER      = center_us(MIN_US, MAX_US);

  slew_state_t       state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [15:0]       pulse_r;
  logic [15:0]       target_r;

  logic              accept_s;
  logic [7:0]        deg_clamp_s;
  logic [23:0]       numer_s;
  logic              div_done_s;
  logic [15:0]       div_quot_s;
  logic [15:0]       new_target_s;
  logic signed [16:0] diff_s;
  logic [16:0]       mag_s;
  logic              step_last_s;
  logic [15:0]       step_pulse_s;

  assign frame_tick   = (cnt_r == CNT_W'(FRAME_TICKS - 1));
  assign accept_s     = cmd_valid && cmd_ready;
  assign deg_clamp_s  = (cmd_deg > 8'(MAX_DEG)) ? 8'(MAX_DEG) : cmd_deg;
  assign numer_s      = 24'(deg_clamp_s) * 24'(MAX_US - MIN_US);
  assign new_target_s = 16'(MIN_US) + div_quot_s;
  assign pulse_us     = pulse_r;

  seq_divider #(.W(24)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (accept_s),
    .numer (numer_s),
    .denom (24'(MAX_DEG)),
    .done  (div_done_s),
    .quot  (div_quot_s)
  );

  // Slew step: 17-bit signed difference keeps the magnitude test wrap-free.
  always_comb begin
    diff_s = $signed({1'b0, target_r}) - $signed({1'b0, pulse_r});
    if (diff_s[16]) begin
      mag_s = $unsigned(-diff_s);
    end else begin
      mag_s = $unsigned(diff_s);
    end
    step_last_s = (mag_s <= 17'(STEP_US));
    if (step_last_s) begin
      step_pulse_s = target_r;
    end else if (diff_s[16]) begin
      step_pulse_s = pulse_r - 16'(STEP_US);
    end else begin
      step_pulse_s = pulse_r + 16'(STEP_US);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; an accept in MOVE wins over reaching the target.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_CONV;
        else          state_nx_s = ST_IDLE;
      end
      ST_CONV: begin
        if (div_done_s) state_nx_s = (new_target_s == pulse_r) ? ST_IDLE : ST_MOVE;
        else            state_nx_s = ST_CONV;
      end
      ST_MOVE: begin
        if (accept_s)                      state_nx_s = ST_CONV;
        else if (frame_tick && step_last_s) state_nx_s = ST_IDLE;
        else                               state_nx_s = ST_MOVE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    case (state_r)
      ST_IDLE: begin cmd_ready = 1'b1; at_target = 1'b1; end
      ST_CONV: begin cmd_ready = 1'b0; at_target = 1'b0; end
      ST_MOVE: begin cmd_ready = 1'b1; at_target = 1'b0; end
      default: begin cmd_ready = 1'b0; at_target = 1'b0; end
    endcase
  end

  // Free-running frame timer, pulse stepping and target latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      pulse_r  <= 16'(CENTER);
      target_r <= 16'(CENTER);
    end else begin
      cnt_r <= frame_tick ? '0 : cnt_r + CNT_W'(1);
      if (state_r == ST_MOVE && frame_tick) begin
        pulse_r <= step_pulse_s;
      end
      if (state_r == ST_CONV && div_done_s) begin
        target_r <= new_target_s;
      end
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with a 20-cycle frame; a second instance
// with a 1000..1180 us range and 7 us step covers the small-step case.
module tb_servo_slew_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_deg = 8'd0;
  logic        cmd_ready;
  logic [15:0] pulse_us;
  logic        at_target;
  logic        frame_tick;

  logic        cmd_valid7 = 1'b0;
  logic [7:0]  cmd_deg7 = 8'd0;
  logic        cmd_ready7;
  logic [15:0] pulse_us7;
  logic        at_target7;
  logic        frame_tick7;

  int n_cmp = 0;
  int n_bad = 0;
  int fc = 0;
  int exp_p = 1500;
  int cur_tgt = 1500;
  bit moving = 1'b0;

  always #5 clk = ~clk;

  servo_slew_ctrl #(.CLK_FREQ(1000), .FRAME_HZ(50)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_deg(cmd_deg), .pulse_us(pulse_us), .at_target(at_target),
    .frame_tick(frame_tick)
  );

  servo_slew_ctrl #(.CLK_FREQ(1000), .FRAME_HZ(50), .MIN_US(1000), .MAX_US(1180),
                    .MAX_DEG(180), .STEP_US(7)) dut7 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid7), .cmd_ready(cmd_ready7),
    .cmd_deg(cmd_deg7), .pulse_us(pulse_us7), .at_target(at_target7),
    .frame_tick(frame_tick7)
  );

  function automatic int next_p(input int p, input int t, input int s);
    int d;
    d = t - p;
    if (d <= s && d >= -s) return t;
    else if (d > 0)        return p + s;
    else                   return p - s;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) fc = 0;
    else if (fc == 19) fc = 0;
    else fc = fc + 1;
    #1;
  endtask

  task automatic do_accept(input int deg, input int tgt, input bit keep);
    cmd_valid = 1'b1;
    cmd_deg   = deg[7:0];
    if (moving && fc == 19) exp_p = next_p(exp_p, cur_tgt, 20);
    tick();
    if (!keep) cmd_valid = 1'b0;
    cur_tgt = tgt;
    moving  = 1'b0;
  endtask

  task automatic conv_phase(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (cmd_ready !== 1'b0 || pulse_us !== 16'(exp_p)) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s conv_hold: %0d bad cycles, required 0 (pulse %0d)", tag, bad, exp_p);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || at_target !== (cur_tgt == exp_p)) begin
      n_bad++;
      $display("FAIL %s conv_end: ready=%b at_target=%b, required ready=1 at_target=%b",
               tag, cmd_ready, at_target, (cur_tgt == exp_p));
    end
    moving = (cur_tgt != exp_p);
  endtask

  task automatic follow(input int stop, input string tag);
    int guard;
    guard = 0;
    while (exp_p != stop && guard < 200) begin
      guard++;
      while (fc != 19) tick();
      n_cmp++;
      if (frame_tick !== 1'b1) begin
        n_bad++;
        $display("FAIL %s frame_tick: got %b required 1", tag, frame_tick);
      end
      exp_p = next_p(exp_p, cur_tgt, 20);
      tick();
      n_cmp++;
      if (pulse_us !== 16'(exp_p)) begin
        n_bad++;
        $display("FAIL %s step: pulse %0d required %0d", tag, pulse_us, exp_p);
      end
    end
    moving = (exp_p != cur_tgt);
    n_cmp++;
    if (guard >= 200 || at_target !== !moving) begin
      n_bad++;
      $display("FAIL %s end: at_target=%b required %b (pulse %0d, stop %0d)",
               tag, at_target, !moving, pulse_us, stop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if (pulse_us !== 16'd1500 || at_target !== 1'b1 || cmd_ready !== 1'b1 || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pulse=%0d at=%b rdy=%b ft=%b required 1500 1 1 0",
               pulse_us, at_target, cmd_ready, frame_tick);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i >= 18) begin
        n_cmp++;
        if (frame_tick !== (i == 19)) begin
          n_bad++;
          $display("FAIL reset_tick_%0d: frame_tick=%b required %b", i, frame_tick, (i == 19));
        end
      end
    end
    exp_p = 1500; cur_tgt = 1500; moving = 1'b0;
  endtask

  task automatic test_full_scale();
    do_accept(180, 2000, 1'b0);
    conv_phase("full");
    follow(2000, "full");
  endtask

  task automatic test_conversion();
    do_accept(45, 1250, 1'b0);  conv_phase("deg45");  follow(1250, "deg45");
    do_accept(200, 2000, 1'b0); conv_phase("deg200"); follow(2000, "deg200");
    do_accept(0, 1000, 1'b0);   conv_phase("deg0");   follow(1000, "deg0");
    do_accept(1, 1005, 1'b0);   conv_phase("deg1");   follow(1005, "deg1");
  endtask

  task automatic test_backpressure();
    do_accept(180, 2000, 1'b1);
    cmd_deg = 8'd90;
    conv_phase("bp_first");
    do_accept(90, 1500, 1'b0);
    conv_phase("bp_second");
    follow(1500, "bp_second");
  endtask

  task automatic test_retarget();
    do_accept(180, 2000, 1'b0); conv_phase("rt_up");
    follow(1700, "rt_up");
    do_accept(0, 1000, 1'b0);   conv_phase("rt_down");
    follow(1000, "rt_down");
    do_accept(180, 2000, 1'b0); conv_phase("co_up");
    follow(1100, "co_up");
    while (fc != 19) tick();
    do_accept(90, 1500, 1'b0);
    conv_phase("co_conv");
    follow(1500, "co_settle");
  endtask

  task automatic test_reset_mid_move();
    do_accept(180, 2000, 1'b0); conv_phase("rm_up");
    follow(1840, "rm_up");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (pulse_us !== 16'd1500 || at_target !== 1'b1 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_move: pulse=%0d at=%b rdy=%b required 1500 1 1",
               pulse_us, at_target, cmd_ready);
    end
    exp_p = 1500; cur_tgt = 1500; moving = 1'b0;
    repeat (30) tick();
    n_cmp++;
    if (pulse_us !== 16'd1500 || at_target !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle_hold: pulse=%0d at=%b required 1500 1", pulse_us, at_target);
    end
  endtask

  task automatic test_small_step();
    cmd_valid7 = 1'b1;
    cmd_deg7   = 8'd100;
    tick();
    cmd_valid7 = 1'b0;
    repeat (24) tick();
    n_cmp++;
    if (cmd_ready7 !== 1'b0 || pulse_us7 !== 16'd1090) begin
      n_bad++;
      $display("FAIL s7_conv: rdy=%b pulse=%0d required 0 1090", cmd_ready7, pulse_us7);
    end
    tick();
    n_cmp++;
    if (cmd_ready7 !== 1'b1 || at_target7 !== 1'b0) begin
      n_bad++;
      $display("FAIL s7_move: rdy=%b at=%b required 1 0", cmd_ready7, at_target7);
    end
    while (fc != 19) tick();
    tick();
    n_cmp++;
    if (pulse_us7 !== 16'd1097 || at_target7 !== 1'b0) begin
      n_bad++;
      $display("FAIL s7_step1: pulse=%0d at=%b required 1097 0", pulse_us7, at_target7);
    end
    while (fc != 19) tick();
    tick();
    n_cmp++;
    if (pulse_us7 !== 16'd1100 || at_target7 !== 1'b1) begin
      n_bad++;
      $display("FAIL s7_step2: pulse=%0d at=%b required 1100 1", pulse_us7, at_target7);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_conversion();
    test_backpressure();
    test_retarget();
    test_reset_mid_move();
    test_small_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
